// File: rtl/irq_ctl_pkg.sv
// irq_pkg: shared constants and helpers for the irq_ctl interrupt controller.
//  - Bus geometry (address/data width) and the register index map.
//  - Field positions of the ACTIVE register.
//  - MAX_NSRC: the widest source vector the register file is built for.
//  - prio_idx(): lowest-index-wins priority encoder.
//  - make_active(): packs {valid, 4'b0, id} into the ACTIVE byte.
package irq_pkg;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 8;
  localparam int MAX_NSRC = 8;

  localparam logic [ADDR_W-1:0] REG_STATUS = 2'd0;
  localparam logic [ADDR_W-1:0] REG_ENABLE = 2'd1;
  localparam logic [ADDR_W-1:0] REG_MODE   = 2'd2;
  localparam logic [ADDR_W-1:0] REG_ACTIVE = 2'd3;

  localparam int ACT_VALID_BIT = 7;
  localparam int ACT_ID_LSB    = 0;
  localparam int ACT_ID_W      = 3;

  // Scan from the top down so the last hit, the lowest set index, is kept.
  function automatic logic [ACT_ID_W-1:0] prio_idx(input logic [MAX_NSRC-1:0] v);
    logic [ACT_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = ACT_ID_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [DATA_W-1:0] make_active(input logic valid,
                                                    input logic [ACT_ID_W-1:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    v[ACT_VALID_BIT] = valid;
    v[ACT_ID_LSB +: ACT_ID_W] = id;
    return v;
  endfunction

endpackage

// File: rtl/irq_ctl_if.sv
// irq_ctl_if: CPU-side connection of the interrupt controller.
//  cs, we, addr, DI : register access from the CPU (qualified by clk)
//  DO               : read data back to the CPU
//  irq_ack, nmi_ack : 1-cycle vector-fetch pulses from the core
//  IRQ, NMI         : interrupt lines to the core
// Modport master is the CPU side, slave is the controller.
interface irq_ctl_if;
  import irq_pkg::*;

  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              irq_ack;
  logic              nmi_ack;
  logic              IRQ;
  logic              NMI;

  modport master (
    output cs, we, addr, DI, irq_ack, nmi_ack,
    input  DO, IRQ, NMI
  );

  modport slave (
    input  cs, we, addr, DI, irq_ack, nmi_ack,
    output DO, IRQ, NMI
  );

endinterface

// File: rtl/irq_ctl_sync_edge.sv
// sync_edge: synchroniser plus rising-edge detector for one async input.
//  clk, rst_n : clock, async active-low reset
//  din        : asynchronous input
//  lvl        : din after SYNC_STAGES flops
//  rise       : one-cycle pulse when lvl goes 0 -> 1
// The history flop always follows lvl, whatever mode the consumer uses,
// so switching a source from level to edge never sees a stale history.
module sync_edge
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Shift din through the synchroniser chain and remember last cycle's level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
      prev   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      prev   <= lvl;
    end
  end

  assign lvl  = stages[SYNC_STAGES-1];
  assign rise = lvl & ~prev;

endmodule

// File: rtl/irq_ctl.sv
// irq_ctl: interrupt controller in front of the 65C02 core.
//  clk     : CPU clock
//  RST_N   : async active-low reset
//  src     : NSRC async interrupt requests (level or edge per MODE bit)
//  nmi_in  : async NMI request, edge-sensitive
//  bus     : CPU register port, vector-fetch acks, IRQ/NMI outputs
// Registers: 0 STATUS (PEND, W1C), 1 ENABLE, 2 MODE, 3 ACTIVE (read-only).
module irq_ctl
  import irq_pkg::*;
#(
  parameter int         NSRC        = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] EDGE_MASK   = 8'h00
) (
  input  logic            clk,
  input  logic            RST_N,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_in,
  irq_ctl_if.slave        bus
);

  // Bits at or above NSRC do not exist and always read back as 0.
  localparam logic [MAX_NSRC-1:0] SRC_MASK = 8'((16'd1 << NSRC) - 16'd1);

  logic [MAX_NSRC-1:0] src_lvl, src_rise;
  logic                nmi_rise, nmi_lvl_unused;

  logic [MAX_NSRC-1:0] pend, enable, mode, pend_nxt;
  logic [DATA_W-1:0]   active, rd_data;
  logic                nmi_pend, irq_q;

  logic                wr, rd, wr_status, wr_enable, wr_mode;
  logic [MAX_NSRC-1:0] w1c, to_level, req, ack_clr;
  logic [ACT_ID_W-1:0] req_idx;
  logic                req_any;

  for (genvar i = 0; i < MAX_NSRC; i++) begin : g_src
    if (i < NSRC) begin : g_used
      sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (RST_N),
        .din   (src[i]),
        .lvl   (src_lvl[i]),
        .rise  (src_rise[i])
      );
    end else begin : g_tied
      assign src_lvl[i]  = 1'b0;
      assign src_rise[i] = 1'b0;
    end
  end

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nmi (
    .clk   (clk),
    .rst_n (RST_N),
    .din   (nmi_in),
    .lvl   (nmi_lvl_unused),
    .rise  (nmi_rise)
  );

  assign wr        = bus.cs & bus.we;
  assign rd        = bus.cs & ~bus.we;
  assign wr_status = wr && (bus.addr == REG_STATUS);
  assign wr_enable = wr && (bus.addr == REG_ENABLE);
  assign wr_mode   = wr && (bus.addr == REG_MODE);

  // Priority, ack and next-PEND. In edge mode a rise always beats a W1C or
  // ack clear landing in the same cycle. An edge->level MODE write drops the
  // latched bit; from the next cycle the bit simply tracks the level.
  always_comb begin
    w1c      = wr_status ? (bus.DI & SRC_MASK) : '0;
    to_level = wr_mode ? (mode & ~(bus.DI & SRC_MASK)) : '0;
    req      = pend & enable;
    req_any  = |req;
    req_idx  = prio_idx(req);
    ack_clr  = (bus.irq_ack && req_any) ? (8'h01 << req_idx) : '0;
    pend_nxt = pend;
    for (int i = 0; i < MAX_NSRC; i++) begin
      if (mode[i]) begin
        pend_nxt[i] = src_rise[i] | (pend[i] & ~w1c[i] & ~ack_clr[i] & ~to_level[i]);
      end else begin
        pend_nxt[i] = src_lvl[i];
      end
    end
  end

  // Register file, ACTIVE capture on ack, NMI latch and registered IRQ.
  // A spurious ack (nothing requesting) leaves ACTIVE at 8'h00.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      pend     <= '0;
      enable   <= '0;
      mode     <= EDGE_MASK & SRC_MASK;
      active   <= '0;
      nmi_pend <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (wr_enable) enable <= bus.DI & SRC_MASK;
      if (wr_mode)   mode   <= bus.DI & SRC_MASK;
      if (bus.irq_ack) active <= req_any ? make_active(1'b1, req_idx) : '0;
      nmi_pend <= nmi_rise | (nmi_pend & ~bus.nmi_ack);
      irq_q    <= req_any;
    end
  end

  // Read data is purely combinational from addr and idles at 0.
  always_comb begin
    rd_data = '0;
    if (rd) begin
      case (bus.addr)
        REG_STATUS: rd_data = pend;
        REG_ENABLE: rd_data = enable;
        REG_MODE:   rd_data = mode;
        REG_ACTIVE: rd_data = active;
        default:    rd_data = '0;
      endcase
    end
  end

  assign bus.DO  = rd_data;
  assign bus.IRQ = irq_q;
  assign bus.NMI = nmi_pend;

endmodule
